load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 8, word-address width of the data memory port.
- DATA_W, 32, data word width; byte lanes are DATA_W/8.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- req, in, 1, pipeline access request; accepted only when busy=0.
- wr, in, 1, 1=store, 0=load; sampled at accept.
- size, in, 2, 00 byte, 01 halfword, 10 word, 11 illegal; sampled at accept.
- sign_ext, in, 1, 1=sign-extend sub-word loads, 0=zero-extend.
- addr, in, 32, byte address.
- wdata, in, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
- busy, out, 1, request in flight; pipeline stalls MEM stage while high.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, valid with done; misaligned, illegal size or out-of-range.
- rdata, out, 32, load result, valid with done.
- dm_we, out, 1, memory write enable; memory writes on the rising clk edge.
- dm_addr, out, ADDR_W, memory word address.
- dm_din, out, 32, memory write data.
- dm_dout, in, 32, memory read data; combinational from dm_addr.

Function
REQ-003 States SHALL be IDLE, READ, WRITE, RESP; busy = (state != IDLE).
REQ-004 In IDLE, req=1 SHALL latch wr, size, sign_ext, addr and wdata at the clock edge.
REQ-005 Error SHALL be detected at accept when any of the following hold:
- size=11;
- size=01 with addr[0]=1;
- size=10 with addr[1:0]!=0;
- addr[31:ADDR_W+2] != 0.
REQ-006 An error request SHALL go IDLE->RESP, issue no dm_we, and pulse done=1 with err=1 and rdata=0.
REQ-007 A load SHALL go IDLE->READ->RESP; in READ, dm_addr = addr[ADDR_W+1:2] and dm_dout is captured at the edge.
REQ-008 A word store SHALL go IDLE->WRITE->RESP, with dm_we=1 and dm_din=wdata for exactly the one WRITE cycle.
REQ-009 A sub-word store SHALL go IDLE->READ->WRITE->RESP (read-modify-write). The READ word is captured, then only the addressed lane(s) are replaced:
- byte lane addr[1:0];
- half lane addr[1].
REQ-010 Byte order SHALL be little-endian: lane k occupies bits [8k+7:8k].
REQ-011 Load result extraction SHALL be:
- byte: lane addr[1:0], extended to 32 bits per sign_ext;
- half: lane addr[1], extended per sign_ext;
- word: unmodified.
REQ-012 done SHALL be high only in RESP, for exactly one cycle; RESP always returns to IDLE.
REQ-013 rdata and err SHALL hold their values from RESP until the next RESP; rdata=0 after a store.
REQ-014 Latency from accept edge to done SHALL be:
- error: 1 cycle;
- load: 2 cycles;
- word store: 2 cycles;
- sub-word store: 3 cycles.
REQ-015 req while busy=1 SHALL be ignored, not queued. A new req SHALL be acceptable in the IDLE cycle following RESP.
REQ-016 dm_we SHALL be 0 in every state except WRITE; dm_addr SHALL be held at the latched word address in READ, WRITE and RESP.
REQ-017 At most one memory write SHALL occur per accepted store; no write for loads or errors.

Reset
REQ-018 rst=1 SHALL immediately force the following, regardless of clk:
- state=IDLE;
- busy=0, done=0, err=0, rdata=0;
- dm_we=0, dm_addr=0, dm_din=0.
REQ-019 Reset asserted during WRITE SHALL deassert dm_we before the next edge, so no memory write occurs; no done pulse SHALL follow.
REQ-020 After rst falls, the first req SHALL be accepted on the next rising edge.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF -> dm_we=1 once at dm_addr=4; load addr=0x10 -> done after 2 cycles, rdata=0xDEADBEEF, err=0.
- Byte RMW: mem[4]=0xDEADBEEF; store byte addr=0x12, wdata=0x55 -> done after 3 cycles, mem[4]=0xDE55BEEF.
- Sign extension: load byte addr=0x13 with sign_ext=1 -> rdata=0xFFFFFFDE; sign_ext=0 -> 0x000000DE; half addr=0x12 sign_ext=1 -> 0xFFFFDE55.
- Errors: half at addr=0x11, word at 0x12, size=11, addr=0x400 -> each done after 1 cycle with err=1, rdata=0, no dm_we.
- Busy: req held high continuously -> back-to-back accepts separated by one IDLE cycle; no request lost or duplicated.
- Reset mid-write: assert rst during WRITE of a store to 0x20 -> dm_we falls immediately, mem[8] unchanged, no done, busy=0.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Connects a pipeline MEM stage to a word-wide synchronous-write data
//   memory. It handles byte, halfword and word loads and stores, with
//   little-endian lane placement. Sub-word loads can be sign-extended or
//   zero-extended. Sub-word stores use a read-modify-write sequence.
//   Misaligned, illegal-size and out-of-range accesses complete with err=1
//   and never touch memory.
//
// Parameters:
//   ADDR_W    word-address width of the data memory port
//   DATA_W    data word width (byte lanes = DATA_W/8)
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req           access request, accepted only while busy=0
//   wr            1=store, 0=load
//   size          00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext      1=sign-extend sub-word loads
//   addr          byte address
//   wdata         right-aligned store data
//   busy          request in flight
//   done          one-cycle completion pulse
//   err           access error, valid with done and held until next done
//   rdata         load result, valid with done and held until next done
//   dm_we         memory write enable
//   dm_addr       memory word address
//   dm_din        memory write data
//   dm_dout       memory read data (combinational from dm_addr)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;

    // Request fields latched at accept
    logic                wr_q;
    logic [1:0]          size_q;
    logic                signExt_q;
    logic [1:0]          byteOff_q;
    logic [15:0]         wdata_q;

    // Registered outputs
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                dmWe_q;
    logic [ADDR_W-1:0]   dmAddr_q;
    logic [DATA_W-1:0]   dmDin_q;

    // Combinational next values
    logic                reqErr_d;
    logic [7:0]          loadByte;
    logic [15:0]         loadHalf;
    logic [DATA_W-1:0]   loadData_d;
    logic [DATA_W-1:0]   storeWord_d;

    // Classify the incoming request before it is accepted. An address is out
    // of range when any bit above the memory's byte-address span is set. A
    // shift is used rather than a part-select so the check stays legal for
    // any ADDR_W.
    always_comb begin
        reqErr_d = 1'b0;
        case (size)
            2'b11:   reqErr_d = 1'b1;
            2'b01:   if (addr[0]) reqErr_d = 1'b1;
            2'b10:   if (addr[1:0] != 2'b00) reqErr_d = 1'b1;
            default: reqErr_d = 1'b0;
        endcase
        if ((addr >> (ADDR_W + 2)) != '0) begin
            reqErr_d = 1'b1;
        end
    end

    // Extract the load result from the word that memory returns during READ.
    // Only the lane that the latched byte offset selects is kept. That lane
    // is then widened with either its top bit or zeros.
    always_comb begin
        loadByte   = dm_dout[{byteOff_q, 3'b000} +: 8];
        loadHalf   = dm_dout[{byteOff_q[1], 4'b0000} +: 16];
        loadData_d = dm_dout;
        case (size_q)
            2'b00:   loadData_d = {{(DATA_W-8){signExt_q & loadByte[7]}}, loadByte};
            2'b01:   loadData_d = {{(DATA_W-16){signExt_q & loadHalf[15]}}, loadHalf};
            default: loadData_d = dm_dout;
        endcase
    end

    // Build the write-back word for a sub-word store. Start from the word
    // read during READ, then overwrite only the addressed byte or halfword.
    always_comb begin
        storeWord_d = dm_dout;
        case (size_q)
            2'b00:   storeWord_d[{byteOff_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   storeWord_d[{byteOff_q[1], 4'b0000} +: 16] = wdata_q;
            default: storeWord_d = dm_dout;
        endcase
    end

    // Main sequencer. Every output is driven from a register, so reset clears
    // it immediately. In particular, a reset during WRITE drops dm_we before
    // the next edge, so the memory write is cancelled. done is a default-low
    // pulse that is set only on the edge that enters RESP. err and rdata
    // change only on that same edge, so they hold their values between
    // responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            signExt_q <= 1'b0;
            byteOff_q <= 2'b00;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            dmWe_q    <= 1'b0;
            dmAddr_q  <= '0;
            dmDin_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q      <= wr;
                        size_q    <= size;
                        signExt_q <= sign_ext;
                        byteOff_q <= addr[1:0];
                        wdata_q   <= wdata[15:0];
                        dmAddr_q  <= addr[ADDR_W+1:2];
                        busy_q    <= 1'b1;
                        if (reqErr_d) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (wr && (size == 2'b10)) begin
                            // A full-word store needs no read, so it goes straight to WRITE
                            state_q <= WRITE;
                            dmWe_q  <= 1'b1;
                            dmDin_q <= wdata;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (wr_q) begin
                        state_q <= WRITE;
                        dmWe_q  <= 1'b1;
                        dmDin_q <= storeWord_d;
                    end else begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= loadData_d;
                    end
                end
                WRITE: begin
                    state_q <= RESP;
                    dmWe_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dmWe_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign dm_we   = dmWe_q;
    assign dm_addr = dmAddr_q;
    assign dm_din  = dmDin_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose:
//   Self-checking bench for load_store_unit. It contains a behavioural memory
//   attached to the DUT's memory port and a transaction-level reference model.
//   The model computes each access result and its completion latency from the
//   address/size/data rules. A per-cycle compare process checks the DUT
//   against the model. Directed requests additionally check hand-computed
//   literal results.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    int compareCount = 0;
    int failCount    = 0;
    int weCount      = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr       (wr),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_dout  (dm_dout)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: asynchronous read, writes on the rising edge while dm_we is high
    logic [31:0] mem [0:DEPTH-1];
    assign dm_dout = mem[dm_addr];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
        forever begin
            @(posedge clk);
            if (dm_we) mem[dm_addr] <= dm_din;
        end
    end

    // One comparison: count it, and report it if it differs
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] refMem [0:DEPTH-1];
    bit          mBusy, mDone, mStore;
    logic        mErr, pErr;
    logic [31:0] mRdata, pRdata, mNewWord;
    logic [7:0]  mWord;
    int          mRemain;

    task publishModel();
        mDone  = 1'b1;
        mErr   = pErr;
        mRdata = pRdata;
        if (mStore) refMem[mWord] = mNewWord;
    endtask

    // The model accepts a request whenever it is idle. It decides the outcome
    // and how many edges later the response appears. The write happens on
    // the last edge before the response.
    initial begin
        int off;
        int lat;
        logic [31:0] old;
        logic [31:0] v;
        logic [31:0] sh;
        for (int i = 0; i < DEPTH; i++) refMem[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
        mBusy = 0; mDone = 0; mStore = 0; mErr = 0; pErr = 0;
        mRdata = 0; pRdata = 0; mNewWord = 0; mWord = 0; mRemain = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mBusy = 0; mDone = 0; mStore = 0; mErr = 0; mRdata = 0; mRemain = 0;
            end else if (mDone) begin
                mDone = 0;
                mBusy = 0;
            end else if (mBusy) begin
                mRemain--;
                if (mRemain == 0) publishModel();
            end else if (req) begin
                off      = int'(addr % 4);
                mWord    = 8'((addr / 4) % DEPTH);
                old      = refMem[mWord];
                pErr     = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) ||
                           (size == 2'd2 && off != 0) || (addr >= 32'(DEPTH * 4));
                pRdata   = 0;
                mStore   = 0;
                mNewWord = 0;
                if (pErr) begin
                    lat = 1;
                end else if (!wr) begin
                    lat = 2;
                    if (size == 2'd0) begin
                        v = (old >> (8 * off)) & 32'hFF;
                        if (sign_ext && v >= 32'h80) v = v | 32'hFFFFFF00;
                    end else if (size == 2'd1) begin
                        v = (old >> (16 * (off / 2))) & 32'hFFFF;
                        if (sign_ext && v >= 32'h8000) v = v | 32'hFFFF0000;
                    end else begin
                        v = old;
                    end
                    pRdata = v;
                end else begin
                    mStore = 1;
                    if (size == 2'd2) begin
                        lat      = 2;
                        mNewWord = wdata;
                    end else if (size == 2'd0) begin
                        lat      = 3;
                        sh       = 32'(8 * off);
                        mNewWord = (old & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
                    end else begin
                        lat      = 3;
                        sh       = 32'(16 * (off / 2));
                        mNewWord = (old & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
                    end
                end
                mBusy   = 1;
                mRemain = lat - 1;
                if (mRemain == 0) publishModel();
            end
        end
    end

    // Per-cycle comparison of every meaningful DUT output against the model
    always @(negedge clk) begin
        if (dm_we) weCount++;
        if (rst) begin
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            checkOutput("rst_err", 32'(err), 32'd0);
            checkOutput("rst_rdata", rdata, 32'd0);
            checkOutput("rst_dm_we", 32'(dm_we), 32'd0);
            checkOutput("rst_dm_addr", 32'(dm_addr), 32'd0);
            checkOutput("rst_dm_din", dm_din, 32'd0);
        end else begin
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("err", 32'(err), 32'(mErr));
            checkOutput("rdata", rdata, mRdata);
            checkOutput("dm_we", 32'(dm_we), 32'(mBusy && !mDone && mStore && mRemain == 1));
            if (mBusy) checkOutput("dm_addr", 32'(dm_addr), 32'(mWord));
            if (mBusy && !mDone && mStore && mRemain == 1) checkOutput("dm_din", dm_din, mNewWord);
            if (mDone && mStore) checkOutput("mem_word", mem[mWord], refMem[mWord]);
        end
    end

    // Issue one request from a negative edge. Then measure the number of
    // rising edges, counting the accept edge, until done is seen. Finally
    // check the literal expectations.
    task automatic applyStimulus(input string name, input logic tWr, input logic [1:0] tSize,
                                 input logic tSext, input logic [31:0] tAddr, input logic [31:0] tData,
                                 input int expLat, input logic expErr, input logic [31:0] expRdata,
                                 input int expWrites);
        int n;
        int w0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_idle"}, 32'(busy), 32'd0);
        w0       = weCount;
        req      = 1'b1;
        wr       = tWr;
        size     = tSize;
        sign_ext = tSext;
        addr     = tAddr;
        wdata    = tData;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        n   = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
        checkOutput({name, "_err"}, 32'(err), 32'(expErr));
        checkOutput({name, "_rdata"}, rdata, expRdata);
        checkOutput({name, "_writes"}, 32'(weCount - w0), 32'(expWrites));
    endtask

    // Safety net: the run must always end on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCnt;
        int w0;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_dm_addr", 32'(dm_addr), 32'd0);
        rst = 1'b0;

        // Word store then load
        applyStimulus("st_word",   1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
        checkOutput("mem4_word", mem[4], 32'hDEADBEEF);
        applyStimulus("ld_word",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

        // Byte read-modify-write
        applyStimulus("st_byte",   1'b1, 2'd0, 1'b0, 32'h12, 32'h55, 3, 1'b0, 32'h0, 1);
        checkOutput("mem4_byte", mem[4], 32'hDE55BEEF);

        // Sub-word loads with both extension modes
        applyStimulus("ld_b13_sx", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE, 0);
        applyStimulus("ld_b13_zx", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'h000000DE, 0);
        applyStimulus("ld_h12_sx", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'hFFFFDE55, 0);
        applyStimulus("ld_h10_zx", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0000BEEF, 0);
        applyStimulus("ld_b10_sx", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFFFEF, 0);
        applyStimulus("ld_b11_zx", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 2, 1'b0, 32'h000000BE, 0);

        // Halfword read-modify-write, only the low 16 data bits land
        applyStimulus("st_half",   1'b1, 2'd1, 1'b0, 32'h10, 32'hAAAA1234, 3, 1'b0, 32'h0, 1);
        applyStimulus("ld_after_h", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDE551234, 0);

        // Error cases: immediate response, no memory write
        applyStimulus("err_half",  1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1, 1'b1, 32'h0, 0);
        applyStimulus("err_word",  1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1, 1'b1, 32'h0, 0);
        applyStimulus("err_size",  1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0);
        applyStimulus("err_range", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1, 1'b1, 32'h0, 0);
        applyStimulus("err_st",    1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF, 1, 1'b1, 32'h0, 0);
        checkOutput("mem4_after_err", mem[4], 32'hDE551234);

        // Highest in-range word
        applyStimulus("st_top",    1'b1, 2'd2, 1'b0, 32'h3FC, 32'h0BADF00D, 2, 1'b0, 32'h0, 1);
        applyStimulus("ld_top",    1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 2, 1'b0, 32'h0BADF00D, 0);
        applyStimulus("ld_top_b",  1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0, 2, 1'b0, 32'h0000000B, 0);

        // Request held high: one accept every three cycles, each written once
        @(negedge clk);
        while (busy) @(negedge clk);
        w0 = weCount; doneCnt = 0;
        req = 1'b1; wr = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h30; wdata = 32'h12345678;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        req = 1'b0;
        checkOutput("held_req_dones", 32'(doneCnt), 32'd4);
        checkOutput("held_req_writes", 32'(weCount - w0), 32'd4);
        checkOutput("held_req_mem", mem[12], 32'h12345678);

        // Reset during WRITE cancels the write and the response
        @(negedge clk);
        while (busy) @(negedge clk);
        checkOutput("mem8_before", mem[8], 32'h52520808);
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req = 1'b0;
        checkOutput("rstw_we_high", 32'(dm_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstw_we_low", 32'(dm_we), 32'd0);
        checkOutput("rstw_busy", 32'(busy), 32'd0);
        checkOutput("rstw_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mem8_after", mem[8], 32'h52520808);
        rst = 1'b0;

        // First request after reset is accepted on the very next edge
        applyStimulus("ld_post_rst", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h52520808, 0);

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
